// File: rtl/sparse_stream_pkg.sv
// Shared definitions for the 17-bit sparse-stream token format.
//   token_t     : bit 16 = control flag, bits 15:0 = payload
//   DONE_TOKEN  : end-of-transfer control token
//   is_ctrl / is_stop / is_done : token classifiers
//   lfsr_seed() : derives the backpressure LFSR seed from a shift offset
package sparse_stream_pkg;

  localparam int TOKEN_W = 17;

  typedef logic [TOKEN_W-1:0] token_t;

  localparam token_t DONE_TOKEN = 17'h10100;

  function automatic logic is_ctrl(input token_t t);
    return t[16];
  endfunction

  // A stop token is a control token whose upper payload byte is zero;
  // the lower byte carries the stop level.
  function automatic logic is_stop(input token_t t);
    return t[16] && (t[15:8] == 8'h00);
  endfunction

  function automatic logic is_done(input token_t t);
    return t == DONE_TOKEN;
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] lfsr_seed(input int ran_shift);
    logic [31:0] prod;
    logic [15:0] s;
    prod = ran_shift * 32'h0000_1F35;
    s    = 16'hACE1 ^ prod[15:0];
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/stream_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to gate sink readiness.
//   clk      : clock
//   load     : synchronous reload of SEED (driven by rst | flush)
//   next_bit : bit 0 of the value the register takes on the coming edge
// The register advances every cycle regardless of traffic.
module stream_lfsr #(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic clk,
  input  logic load,
  output logic next_bit
);

  logic [15:0] state;
  logic [15:0] state_d;
  logic        fb;

  always_comb begin
    fb      = state[15] ^ state[13] ^ state[12] ^ state[10];
    state_d = load ? SEED : {state[14:0], fb};
  end

  always_ff @(posedge clk) begin
    state <= state_d;
  end

  assign next_bit = state_d[0];

endmodule

// File: rtl/sparse_stream_sink.sv
// Receiving end of the 17-bit sparse-stream valid/ready protocol.
// Captures every accepted token into a readback buffer, classifies
// data/stop/done tokens, counts active cycles and raises a sticky done.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : synchronous clear, identical effect to rst
//   bp_en           : 1 = ready additionally gated by LFSR bit 0
//   data, valid     : incoming token
//   ready           : registered sink ready
//   done            : sticky, TX_NUM done tokens accepted
//   full            : buffer holds DEPTH tokens
//   rd_addr/rd_data : readback port, 1-cycle registered read
//   tok_count       : tokens captured
//   stop_count      : stop tokens accepted (saturating)
//   cycle_count     : cycles from first valid until done (saturating)
//
// Handshake: a token transfers on every rising edge where valid and ready
// are both 1. The source holds data stable while valid is high and not yet
// accepted; valid may drop without a transfer. ready is a register computed
// from next-state values, so it falls in the same cycle the last permitted
// token lands and no extra token is ever accepted.
module sparse_stream_sink
  import sparse_stream_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int TX_NUM    = 1,
  parameter int RAN_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       bp_en,
  input  logic [TOKEN_W-1:0]         data,
  input  logic                       valid,
  output logic                       ready,
  output logic                       done,
  output logic                       full,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [TOKEN_W-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]     tok_count,
  output logic [15:0]                stop_count,
  output logic [31:0]                cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(TX_NUM + 1);
  localparam logic [15:0]   SEED      = lfsr_seed(RAN_SHIFT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0] TX_NUM_C  = DW'(TX_NUM);

  token_t          mem [DEPTH];
  logic            clr;
  logic            fire;
  logic            lfsr_bit_d;
  logic [AW-1:0]   wr_ptr;
  logic [DW-1:0]   done_cnt;
  logic [DW-1:0]   done_cnt_d;
  logic [CW-1:0]   tok_count_d;
  logic            done_d;
  logic            ready_d;
  logic            started;

  stream_lfsr #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .load     (clr),
    .next_bit (lfsr_bit_d)
  );

  assign clr  = rst | flush;
  // A token offered on the same edge as a clear is dropped; the source re-offers it.
  assign fire = valid & ready & ~clr;
  assign full = (tok_count == DEPTH_C);

  always_comb begin
    tok_count_d = tok_count;
    done_cnt_d  = done_cnt;
    done_d      = done;
    if (clr) begin
      tok_count_d = '0;
      done_cnt_d  = '0;
      done_d      = 1'b0;
    end else if (fire) begin
      tok_count_d = tok_count + 1'b1;
      if (is_done(data)) begin
        done_cnt_d = done_cnt + 1'b1;
        if (done_cnt_d == TX_NUM_C) done_d = 1'b1;
      end
    end
    ready_d = ~clr & ~done_d & (tok_count_d < DEPTH_C) & (bp_en ? lfsr_bit_d : 1'b1);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ready       <= 1'b0;
      done        <= 1'b0;
      tok_count   <= '0;
      done_cnt    <= '0;
      wr_ptr      <= '0;
      stop_count  <= '0;
      cycle_count <= '0;
      started     <= 1'b0;
      rd_data     <= '0;
    end else begin
      ready     <= ready_d;
      done      <= done_d;
      tok_count <= tok_count_d;
      done_cnt  <= done_cnt_d;
      rd_data   <= mem[rd_addr];
      if (fire && (wr_ptr != LAST_ADDR)) wr_ptr <= wr_ptr + 1'b1;
      if (fire && is_stop(data) && (stop_count != 16'hFFFF))
        stop_count <= stop_count + 16'd1;
      if (valid) started <= 1'b1;
      // The cycle that first sees valid is counted, hence (started | valid).
      if ((started | valid) && !done && (cycle_count != 32'hFFFF_FFFF))
        cycle_count <= cycle_count + 32'd1;
    end
  end

  // Capture RAM: contents survive reset/flush.
  always_ff @(posedge clk) begin
    if (fire) mem[wr_ptr] <= data;
  end

endmodule

// File: tb/tb_sparse_stream_sink.sv
module tb_sparse_stream_sink;

  localparam logic [16:0] DONE_TOK = 17'h10100;
  // 16'hACE1 ^ (2 * 16'h1F35) = 16'hACE1 ^ 16'h3E6A
  localparam logic [15:0] SEED_A = 16'h928B;

  // ---------------- clock / reset / shared inputs ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        bp_en = 1'b0;
  logic        valid = 1'b0;
  logic [16:0] data = '0;
  logic [7:0]  rd_addr = '0;

  always #5 clk = ~clk;

  // instance a: DEPTH=256, TX_NUM=1, RAN_SHIFT=2
  logic ready_a, done_a, full_a;
  logic [16:0] rd_data_a;
  logic [8:0]  tok_a;
  logic [15:0] stop_a;
  logic [31:0] cyc_a;
  // instance b: DEPTH=4
  logic ready_b, done_b, full_b;
  logic [16:0] rd_data_b;
  logic [2:0]  tok_b;
  logic [15:0] stop_b;
  logic [31:0] cyc_b;
  // instance c: TX_NUM=2
  logic ready_c, done_c, full_c;
  logic [16:0] rd_data_c;
  logic [8:0]  tok_c;
  logic [15:0] stop_c;
  logic [31:0] cyc_c;

  sparse_stream_sink #(.DEPTH(256), .TX_NUM(1), .RAN_SHIFT(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bp_en(bp_en), .data(data), .valid(valid),
    .ready(ready_a), .done(done_a), .full(full_a), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .tok_count(tok_a), .stop_count(stop_a), .cycle_count(cyc_a)
  );

  sparse_stream_sink #(.DEPTH(4), .TX_NUM(1), .RAN_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bp_en(bp_en), .data(data), .valid(valid),
    .ready(ready_b), .done(done_b), .full(full_b), .rd_addr(rd_addr[1:0]), .rd_data(rd_data_b),
    .tok_count(tok_b), .stop_count(stop_b), .cycle_count(cyc_b)
  );

  sparse_stream_sink #(.DEPTH(256), .TX_NUM(2), .RAN_SHIFT(0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .bp_en(bp_en), .data(data), .valid(valid),
    .ready(ready_c), .done(done_c), .full(full_c), .rd_addr(rd_addr), .rd_data(rd_data_c),
    .tok_count(tok_c), .stop_count(stop_c), .cycle_count(cyc_c)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] lfsr_m   = 16'h0000;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  // Also tracks the expected LFSR state of instance a.
  task automatic tick();
    logic clr_now;
    clr_now = rst | flush;
    @(posedge clk);
    lfsr_m = clr_now ? SEED_A : lfsr_step(lfsr_m);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  function automatic logic [16:0] rdat(input int sel);
    case (sel)
      0:       return rd_data_a;
      1:       return rd_data_b;
      default: return rd_data_c;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int sel, input logic [16:0] tok, input string tag);
    logic acc;
    acc   = 1'b0;
    valid = 1'b1;
    data  = tok;
    for (int i = 0; i < 100; i++) begin
      if (rdy(sel)) begin
        acc = 1'b1;
        tick();
        break;
      end
      tick();
    end
    valid = 1'b0;
    check({tag, "_accepted"}, {31'd0, acc}, 32'd1);
  endtask

  task automatic read_check(input int sel, input int addr, input logic [16:0] exp, input string tag);
    rd_addr = 8'(addr);
    tick();
    check(tag, {15'd0, rdat(sel)}, {15'd0, exp});
  endtask

  function automatic logic [16:0] gold3(input int i);
    logic [15:0] v;
    v = 16'(i * 773 + 11);
    return (i < 50) ? {1'b0, v} : DONE_TOK;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    logic saw0, saw1, fired;

    // ---- reset state + test 1: basic classification ----
    bp_en = 1'b0;
    do_reset();
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_done",  {31'd0, done_a},  32'd0);
    check("rst_full",  {31'd0, full_a},  32'd0);
    check("rst_tok",   32'(tok_a),       32'd0);
    check("rst_stop",  32'(stop_a),      32'd0);
    check("rst_cyc",   cyc_a,            32'd0);
    check("rst_rd",    32'(rd_data_a),   32'd0);
    exp_q = '{17'h00005, 17'h00007, 17'h10000, DONE_TOK};
    send(0, exp_q[0], "t1_0");
    check("t1_ready_after_first", {31'd0, ready_a}, 32'd1);
    send(0, exp_q[1], "t1_1");
    send(0, exp_q[2], "t1_2");
    check("t1_stop_before_done", 32'(stop_a), 32'd1);
    check("t1_done_before",      {31'd0, done_a}, 32'd0);
    send(0, exp_q[3], "t1_3");
    check("t1_done",       {31'd0, done_a},  32'd1);
    check("t1_ready_off",  {31'd0, ready_a}, 32'd0);
    check("t1_tok",        32'(tok_a),       32'd4);
    check("t1_stop",       32'(stop_a),      32'd1);
    for (int i = 0; i < 4; i++) read_check(0, i, exp_q[i], $sformatf("t1_mem%0d", i));

    // ---- test 5: cycle_count from first valid to done ----
    do_reset();
    repeat (9) tick();
    for (int i = 0; i < 20; i++) begin
      send(0, 17'(i + 100), "t5_data");
      if (i == 9) check("t5_cyc_mid", cyc_a, 32'd10);
    end
    send(0, DONE_TOK, "t5_done_tok");
    check("t5_done", {31'd0, done_a}, 32'd1);
    check("t5_cyc",  cyc_a,           32'd21);
    repeat (5) tick();
    check("t5_cyc_frozen", cyc_a, 32'd21);

    // ---- test 3: LFSR backpressure, 50 tokens + DONE ----
    bp_en = 1'b1;
    do_reset();
    check("t3_ready_first", {31'd0, ready_a}, 32'd0);
    tick();
    idx = 0; saw0 = 1'b0; saw1 = 1'b0;
    valid = 1'b1;
    data  = gold3(0);
    for (int c = 0; c < 1000 && idx < 51; c++) begin
      check("t3_ready", {31'd0, ready_a}, {31'd0, lfsr_m[0]});
      if (ready_a) saw1 = 1'b1; else saw0 = 1'b1;
      fired = ready_a;
      tick();
      if (fired) begin
        idx++;
        if (idx < 51) data = gold3(idx);
      end
    end
    valid = 1'b0;
    check("t3_all_sent", 32'(idx), 32'd51);
    check("t3_toggled",  {31'd0, saw0 & saw1}, 32'd1);
    check("t3_tok",      32'(tok_a), 32'd51);
    check("t3_done",     {31'd0, done_a}, 32'd1);
    check("t3_ready_off", {31'd0, ready_a}, 32'd0);
    for (int i = 0; i < 51; i++) read_check(0, i, gold3(i), $sformatf("t3_mem%0d", i));
    bp_en = 1'b0;

    // ---- test 6: reset mid-stream, then flush ----
    do_reset();
    send(0, 17'h00011, "t6_a");
    send(0, 17'h00022, "t6_b");
    send(0, 17'h00033, "t6_c");
    valid = 1'b1;
    data  = 17'h00044;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    check("t6_ready", {31'd0, ready_a}, 32'd0);
    check("t6_tok",   32'(tok_a),       32'd0);
    check("t6_done",  {31'd0, done_a},  32'd0);
    check("t6_cyc",   cyc_a,            32'd0);
    send(0, 17'h00044, "t6_d");
    send(0, 17'h00055, "t6_e");
    send(0, DONE_TOK,  "t6_f");
    check("t6_tok_after", 32'(tok_a), 32'd3);
    read_check(0, 0, 17'h00044, "t6_mem0");
    read_check(0, 1, 17'h00055, "t6_mem1");
    read_check(0, 2, DONE_TOK,  "t6_mem2");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_done",  {31'd0, done_a},  32'd0);
    check("fl_tok",   32'(tok_a),       32'd0);
    check("fl_ready", {31'd0, ready_a}, 32'd0);
    check("fl_cyc",   cyc_a,            32'd0);
    check("fl_rd",    32'(rd_data_a),   32'd0);

    // ---- test 2: DEPTH=4 fills, upstream stalls ----
    do_reset();
    exp_q = '{17'h00A01, 17'h00A02, 17'h00A03, 17'h00A04};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("t2_not_full", {31'd0, full_b}, 32'd0);
      send(1, exp_q[i], "t2_data");
    end
    check("t2_full",      {31'd0, full_b},  32'd1);
    check("t2_ready_off", {31'd0, ready_b}, 32'd0);
    check("t2_tok",       32'(tok_b),       32'd4);
    valid = 1'b1;
    data  = 17'h00A05;
    for (int i = 0; i < 6; i++) begin
      check("t2_stall_ready", {31'd0, ready_b}, 32'd0);
      tick();
    end
    check("t2_tok_hold",  32'(tok_b),      32'd4);
    check("t2_full_hold", {31'd0, full_b}, 32'd1);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) read_check(1, i, exp_q[i], $sformatf("t2_mem%0d", i));

    // ---- test 4: TX_NUM=2 ----
    do_reset();
    send(2, 17'h00001, "t4_a");
    send(2, DONE_TOK,  "t4_b");
    check("t4_done_first",  {31'd0, done_c},  32'd0);
    check("t4_ready_first", {31'd0, ready_c}, 32'd1);
    tick();
    check("t4_done_still",  {31'd0, done_c},  32'd0);
    send(2, 17'h00002, "t4_c");
    send(2, DONE_TOK,  "t4_d");
    check("t4_done",      {31'd0, done_c},  32'd1);
    check("t4_ready_off", {31'd0, ready_c}, 32'd0);
    check("t4_tok",       32'(tok_c),       32'd4);
    valid = 1'b1;
    data  = 17'h00003;
    repeat (5) tick();
    valid = 1'b0;
    check("t4_tok_refused", 32'(tok_c),      32'd4);
    check("t4_done_sticky", {31'd0, done_c}, 32'd1);

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
